// File: rtl/cube_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cube_pkg
// Purpose  : Shared cube-net constants, colour map and net layout helpers
// Revision : 1.0
// ============================================================================
package cube_pkg;

  localparam int NUM_FACELETS = 54;

  localparam logic [2:0] FACE_U    = 3'd0;
  localparam logic [2:0] FACE_L    = 3'd1;
  localparam logic [2:0] FACE_F    = 3'd2;
  localparam logic [2:0] FACE_R    = 3'd3;
  localparam logic [2:0] FACE_B    = 3'd4;
  localparam logic [2:0] FACE_D    = 3'd5;
  localparam logic [2:0] FACE_NONE = 3'd7;

  localparam logic [2:0] COL_WHITE  = 3'd0;
  localparam logic [2:0] COL_YELLOW = 3'd1;
  localparam logic [2:0] COL_RED    = 3'd2;
  localparam logic [2:0] COL_ORANGE = 3'd3;
  localparam logic [2:0] COL_BLUE   = 3'd4;
  localparam logic [2:0] COL_GREEN  = 3'd5;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  function automatic rgb332_t rgb332(input logic [2:0] code);
    case (code)
      COL_WHITE:  rgb332 = {3'd7, 3'd7, 2'd3};
      COL_YELLOW: rgb332 = {3'd7, 3'd7, 2'd0};
      COL_RED:    rgb332 = {3'd7, 3'd0, 2'd0};
      COL_ORANGE: rgb332 = {3'd7, 3'd3, 2'd0};
      COL_BLUE:   rgb332 = {3'd0, 3'd0, 2'd3};
      COL_GREEN:  rgb332 = {3'd0, 3'd7, 2'd0};
      default:    rgb332 = {3'd3, 3'd3, 2'd1};
    endcase
  endfunction

  // Cross layout: U above F, L/F/R/B across the middle band, D below F
  function automatic logic [2:0] face_from_cell(input logic [3:0] col, input logic [3:0] row);
    face_from_cell = FACE_NONE;
    if (row < 4'd3) begin
      if (col >= 4'd3 && col <= 4'd5) face_from_cell = FACE_U;
    end else if (row < 4'd6) begin
      if (col <= 4'd2)       face_from_cell = FACE_L;
      else if (col <= 4'd5)  face_from_cell = FACE_F;
      else if (col <= 4'd8)  face_from_cell = FACE_R;
      else if (col <= 4'd11) face_from_cell = FACE_B;
    end else if (row < 4'd9) begin
      if (col >= 4'd3 && col <= 4'd5) face_from_cell = FACE_D;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cube_net_renderer_if.sv
`default_nettype none
// ============================================================================
// Interface : cube_net_renderer_if
// Purpose   : Solver-side facelet write and commit handshake
// Revision  : 1.0
// ============================================================================
interface cube_net_renderer_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [2:0] wr_color;
  logic       wr_ready;
  logic       commit;
  logic       busy;
  logic       commit_done;

  modport master (
    output wr_en, wr_addr, wr_color, commit,
    input  wr_ready, busy, commit_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_color, commit,
    output wr_ready, busy, commit_done
  );
endinterface
`default_nettype wire

// File: rtl/facelet_buffer.sv
`default_nettype none
// ============================================================================
// Module   : facelet_buffer
// Purpose  : Double-buffered facelet store with blanking-synchronised commit
// Revision : 1.0
// ============================================================================
module facelet_buffer
  import cube_pkg::*;
#(
  parameter int VFP = 511
) (
  input  wire logic        clk,
  input  wire logic        clr_n,
  input  wire logic [9:0]  hc,
  input  wire logic [9:0]  vc,
  cube_net_renderer_if.slave bus,
  input  wire logic [5:0]  rd_addr,
  output logic      [2:0]  rd_code
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_COPY = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [5:0] r_idx;
  logic       w_last;
  logic       w_busy;
  logic       w_copy;
  logic [2:0] r_shadow [NUM_FACELETS];
  logic [2:0] r_active [NUM_FACELETS];

  assign w_last = (r_idx == 6'(NUM_FACELETS - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.commit) w_next = ST_WAIT;
      ST_WAIT: if (hc == 10'd0 && vc == 10'(VFP)) w_next = ST_COPY;
      ST_COPY: if (w_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy          = (r_state != ST_IDLE);
    w_copy          = (r_state == ST_COPY);
    bus.busy        = w_busy;
    bus.wr_ready    = !w_busy;
    bus.commit_done = w_copy && w_last;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                 r_idx <= '0;
    else if (r_state == ST_WAIT) r_idx <= '0;
    else if (w_copy)             r_idx <= r_idx + 6'd1;
  end

  // Both copies come out of reset holding the solved cube
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_FACELETS; i++) begin
        r_shadow[i] <= 3'(i / 9);
        r_active[i] <= 3'(i / 9);
      end
    end else begin
      if (bus.wr_en && !w_busy && bus.wr_addr < 6'(NUM_FACELETS))
        r_shadow[bus.wr_addr] <= bus.wr_color;
      if (w_copy)
        r_active[r_idx] <= r_shadow[r_idx];
    end
  end

  assign rd_code = (rd_addr < 6'(NUM_FACELETS)) ? r_active[rd_addr] : 3'd0;

endmodule
`default_nettype wire

// File: rtl/cube_net_renderer.sv
`default_nettype none
// ============================================================================
// Module   : cube_net_renderer
// Purpose  : Cube-net pixel colour stage; RGB332 and syncs 2 cycles after hc/vc
// Revision : 1.0
// ============================================================================
module cube_net_renderer
  import cube_pkg::*;
#(
  parameter int HPIXELS = 800,
  parameter int HBP     = 144,
  parameter int VBP     = 31,
  parameter int VFP     = 511,
  parameter int NET_X0  = 80,
  parameter int NET_Y0  = 60,
  parameter int FS      = 40,
  parameter int BORDER  = 2
) (
  input  wire logic        clk,
  input  wire logic        clr_n,
  input  wire logic [9:0]  hc,
  input  wire logic [9:0]  vc,
  input  wire logic        hsync_in,
  input  wire logic        vsync_in,
  cube_net_renderer_if.slave bus,
  output logic             hsync,
  output logic             vsync,
  output logic      [2:0]  red,
  output logic      [2:0]  green,
  output logic      [1:0]  blue
);

  localparam logic [9:0] c_x0 = 10'(HBP + NET_X0);
  localparam logic [9:0] c_y0 = 10'(VBP + NET_Y0);
  localparam logic [9:0] c_x1 = 10'(HBP + NET_X0 + 12 * FS);
  localparam logic [9:0] c_y1 = 10'(VBP + NET_Y0 + 9 * FS);

  logic [5:0] r_px, w_px;
  logic [3:0] r_col, w_col;
  logic [1:0] r_csub, w_csub;
  logic [5:0] r_py;
  logic [3:0] r_row;
  logic [1:0] r_rsub;
  logic [2:0] w_face;
  logic       w_in_net;
  logic       w_border;
  logic [5:0] w_addr;
  logic       r_s1_on;
  logic [5:0] r_s1_addr;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic [2:0] w_code;
  rgb332_t    w_rgb;

  // Column counters restart combinationally so hc == x0 already decodes as px 0
  always_comb begin
    w_px   = r_px;
    w_col  = r_col;
    w_csub = r_csub;
    if (hc == c_x0) begin
      w_px   = '0;
      w_col  = '0;
      w_csub = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_px   <= '0;
      r_col  <= '0;
      r_csub <= '0;
    end else if (w_px == 6'(FS - 1)) begin
      r_px   <= '0;
      r_col  <= (w_col == 4'hF) ? w_col : w_col + 4'd1;
      r_csub <= (w_csub == 2'd2) ? 2'd0 : w_csub + 2'd1;
    end else begin
      r_px   <= w_px + 6'd1;
      r_col  <= w_col;
      r_csub <= w_csub;
    end
  end

  // Row counters step at end of line and restart on entry to the first net line
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_py   <= '0;
      r_row  <= '0;
      r_rsub <= '0;
    end else if (hc == 10'(HPIXELS - 1)) begin
      if (vc == c_y0 - 10'd1) begin
        r_py   <= '0;
        r_row  <= '0;
        r_rsub <= '0;
      end else if (r_py == 6'(FS - 1)) begin
        r_py   <= '0;
        r_row  <= (r_row == 4'hF) ? r_row : r_row + 4'd1;
        r_rsub <= (r_rsub == 2'd2) ? 2'd0 : r_rsub + 2'd1;
      end else begin
        r_py <= r_py + 6'd1;
      end
    end
  end

  assign w_face   = face_from_cell(w_col, r_row);
  assign w_in_net = (hc >= c_x0) && (hc < c_x1) && (vc >= c_y0) && (vc < c_y1)
                    && (w_face != FACE_NONE);
  assign w_border = (w_px < 6'(BORDER)) || (r_py < 6'(BORDER));
  assign w_addr   = {w_face, 3'b000} + 6'(w_face) + 6'({r_rsub, 1'b0})
                    + 6'(r_rsub) + 6'(w_csub);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_s1_on   <= 1'b0;
      r_s1_addr <= '0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
    end else begin
      r_s1_on   <= w_in_net && !w_border;
      r_s1_addr <= w_addr;
      r_s1_hs   <= hsync_in;
      r_s1_vs   <= vsync_in;
    end
  end

  facelet_buffer #(
    .VFP (VFP)
  ) u_buf (
    .clk     (clk),
    .clr_n   (clr_n),
    .hc      (hc),
    .vc      (vc),
    .bus     (bus),
    .rd_addr (r_s1_addr),
    .rd_code (w_code)
  );

  assign w_rgb = rgb332(w_code);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      red   <= r_s1_on ? w_rgb.r : 3'd0;
      green <= r_s1_on ? w_rgb.g : 3'd0;
      blue  <= r_s1_on ? w_rgb.b : 2'd0;
      hsync <= r_s1_hs;
      vsync <= r_s1_vs;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cube_net_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cube_net_renderer
// Purpose  : Randomised self-checking bench for cube_net_renderer
// Revision : 1.0
// ============================================================================
module tb_cube_net_renderer;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [9:0] hc = '0;
  logic [9:0] vc = '0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       hsync, vsync;
  logic [2:0] red, green;
  logic [1:0] blue;

  cube_net_renderer_if bus ();

  cube_net_renderer dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .hc       (hc),
    .vc       (vc),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .bus      (bus),
    .hsync    (hsync),
    .vsync    (vsync),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [9:0] val;
    bit         chk;
    string      tag;
  } ent_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_shadow [54];
  int   m_active [54];
  bit   m_pending;
  int   m_copied;
  ent_t q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 54; i++) begin
      m_shadow[i] = i / 9;
      m_active[i] = i / 9;
    end
    m_pending = 1'b0;
    m_copied  = -1;
  endfunction

  function automatic logic [7:0] code_rgb(input int c);
    case (c)
      0:       return 8'b111_111_11;
      1:       return 8'b111_111_00;
      2:       return 8'b111_000_00;
      3:       return 8'b111_011_00;
      4:       return 8'b000_000_11;
      5:       return 8'b000_111_00;
      default: return 8'b011_011_01;
    endcase
  endfunction

  // Expected pixel straight from the net geometry with plain division
  function automatic logic [7:0] exp_pix(input int h, input int v);
    int col, row, px, py, face;
    if (h < 224 || h >= 704 || v < 91 || v >= 451) return 8'd0;
    col = (h - 224) / 40;  px = (h - 224) % 40;
    row = (v - 91) / 40;   py = (v - 91) % 40;
    if (px < 2 || py < 2) return 8'd0;
    if (row < 3)      face = (col >= 3 && col <= 5) ? 0 : -1;
    else if (row < 6) face = 1 + col / 3;
    else              face = (col >= 3 && col <= 5) ? 5 : -1;
    if (face < 0) return 8'd0;
    return code_rgb(m_active[face * 9 + (row % 3) * 3 + (col % 3)]);
  endfunction

  task automatic check_ctl(input string tag);
    bit eb;
    eb = m_pending || (m_copied >= 0);
    check({tag, "_busy"}, 32'(bus.busy), 32'(eb));
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(!eb));
    check({tag, "_commit_done"}, 32'(bus.commit_done), 32'(m_copied == 53));
  endtask

  task automatic step(input int h, input int v, input bit we, input int wa, input int wc,
                      input bit cm, input bit pchk, input bit cchk, input string tag);
    ent_t e, o;
    bit   was_busy;
    hc           = 10'(h);
    vc           = 10'(v);
    hsync_in     = 1'($urandom_range(0, 1));
    vsync_in     = 1'($urandom_range(0, 1));
    bus.wr_en    = we;
    bus.wr_addr  = 6'(wa);
    bus.wr_color = 3'(wc);
    bus.commit   = cm;
    e.val = {exp_pix(h, v), hsync_in, vsync_in};
    e.chk = pchk;
    e.tag = tag;
    was_busy = m_pending || (m_copied >= 0);
    @(posedge clk);
    #1;
    if (we && !was_busy && wa < 54) m_shadow[wa] = wc;
    if (m_copied >= 0) begin
      m_copied++;
      if (m_copied == 54) begin
        m_active = m_shadow;
        m_copied = -1;
      end
    end else if (m_pending) begin
      if (h == 0 && v == 511) begin
        m_pending = 1'b0;
        m_copied  = 0;
      end
    end else if (cm) begin
      m_pending = 1'b1;
    end
    if (q.size() > 0) begin
      o = q.pop_front();
      if (o.chk) check(o.tag, 32'({red, green, blue, hsync, vsync}), 32'(o.val));
    end
    q.push_back(e);
    if (cchk) check_ctl("ctl");
  endtask

  task automatic do_reset(input string tag);
    #5 clr_n = 1'b0;
    #1;
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(1));
    check({tag, "_done"}, 32'(bus.commit_done), 32'(0));
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'(0));
    check({tag, "_syncs"}, 32'({hsync, vsync}), 32'(3));
    model_reset();
    q.delete();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic run_frame(input int nwr, input int wr_line, input int wa_f, input int wc_f,
                           input int cm_line, input int cm2_line, input int rst_idx);
    int lines [5];
    lines[0] = 100;
    lines[1] = 220;
    lines[2] = $urandom_range(91, 450);
    lines[3] = $urandom_range(91, 450);
    lines[4] = $urandom_range(470, 500);
    for (int v = 0; v < 521; v++) begin
      bit full = 1'b0;
      foreach (lines[k]) if (lines[k] == v) full = 1'b1;
      if (full) begin
        for (int h = 96; h < 720; h++) begin
          string tag = "pix";
          bit    pc  = ($urandom_range(0, 7) == 0);
          if ((v == 100 && (h == 350 || h == 344 || h == 230 || h == 100)) ||
              (v == 220 && h == 350)) begin
            pc  = 1'b1;
            tag = $sformatf("pix_%0d_%0d", h, v);
          end
          step(h, v, 0, 0, 0, 0, pc, 0, tag);
        end
        step(799, v, 0, 0, 0, 0, 0, 0, "eol");
      end else if (v == 511) begin
        for (int h = 0; h < 81; h++) begin
          step(h, v, 0, 0, 0, 0, 0, 1, "blank");
          if (rst_idx >= 0 && m_copied == rst_idx) do_reset("rst_copy");
        end
        step(799, v, 0, 0, 0, 0, 0, 1, "blank");
      end else begin
        bit we = 1'b0;
        bit cm = 1'b0;
        int wa = 0;
        int wc = 0;
        if (v >= 1 && v <= nwr) begin
          we = 1'b1;
          wa = $urandom_range(0, 63);
          wc = $urandom_range(0, 7);
        end
        if (v == wr_line) begin
          we = 1'b1;
          wa = wa_f;
          wc = wc_f;
        end
        if (v == cm_line || v == cm2_line) cm = 1'b1;
        step(799, v, we, wa, wc, cm, 0, we || cm, "ctl");
      end
    end
  endtask

  initial begin
    model_reset();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_color = '0;
    bus.commit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", 32'({red, green, blue}), 32'(0));
    check("reset_syncs", 32'({hsync, vsync}), 32'(3));
    check("reset_wr_ready", 32'(bus.wr_ready), 32'(1));
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_done", 32'(bus.commit_done), 32'(0));
    @(negedge clk);
    clr_n = 1'b1;

    run_frame(0, -1, 0, 0, -1, -1, -1);           // solved cube
    run_frame(0, 1, 18, 4, -1, -1, -1);           // shadow write only
    run_frame(0, 460, 0, 5, 2, 461, -1);          // commit, then write/commit while busy
    run_frame(0, -1, 0, 0, -1, -1, -1);           // published image
    for (int f = 0; f < 3; f++)
      run_frame(30, -1, 0, 0, 30, -1, -1);        // random writes, commit with last write
    run_frame(10, -1, 0, 0, 12, -1, 20);          // reset part-way through the copy
    run_frame(0, -1, 0, 0, -1, -1, -1);           // back to solved

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
